// File: rtl/ace_pkg.sv
// Shared types and sizing for the system ROM image loader.
package ace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LAST,
    DONE
  } loader_state_t;

  localparam int unsigned ROM_AW    = 13;
  localparam int unsigned ROM_DEPTH = 8192;

endpackage

// File: rtl/rom_loader.sv
// Streams a boot image into the ROM/shadow RAM from address 0, holds the CPU
// in reset until the image is complete and keeps an 8-bit additive checksum.
module rom_loader
  import ace_pkg::*;
#(
  parameter int unsigned AW    = ROM_AW,
  parameter int unsigned DEPTH = ROM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic          cpu_rst_n,
  output logic [7:0]    checksum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  loader_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic [7:0]    checksum_q, checksum_d;
  logic          mem_we_q, mem_we_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          accept;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_a_d    = mem_a_q;
    mem_din_d  = mem_din_q;
    checksum_d = checksum_q;
    mem_we_d   = 1'b0;
    accept     = in_valid && in_ready_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          addr_d     = '0;
          checksum_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_a_d    = addr_q;
          mem_din_d  = in_data;
          checksum_d = checksum_q + in_data;
          // The address parks on the final location instead of wrapping.
          if (addr_q == LAST_ADDR) begin
            state_d = LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      LAST: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies decoded from the next state.
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d == LOAD) || (state_d == LAST);
    done_d      = (state_d == DONE);
    cpu_rst_n_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mem_a_q     <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_a_q     <= mem_a_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      checksum_q  <= checksum_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_a     = mem_a_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: full loads, gapped stream, overrun, mid-load reset, reload.
module tb_rom_loader;

  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          cpu_rst_n;
  logic [7:0]    checksum;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rom_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_a    (mem_a),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .cpu_rst_n(cpu_rst_n),
    .checksum (checksum)
  );

  // Driver only: pulses start for one cycle, returns at the negedge after it.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({in_ready, mem_we, busy, done, cpu_rst_n, mem_a, mem_din, checksum} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h",
               {in_ready, mem_we, busy, done, cpu_rst_n, mem_a, mem_din, checksum}, 34'h0);
    end
  endtask

  task automatic test_idle();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({in_ready, mem_we, cpu_rst_n, done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle_outputs cycle %0d: got %b expected 0000", i, {in_ready, mem_we, cpu_rst_n, done});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 8'(i + 3);
      @(negedge clk);
    end
    vectors++;
    if ({mem_we, mem_a} !== {1'b1, 13'd99}) begin
      miscompares++;
      $display("FAIL mid_load_addr: got we=%b a=%0d expected we=1 a=99", mem_we, mem_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready, cpu_rst_n, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b expected 000", {in_ready, cpu_rst_n, busy});
    end
    in_valid = 1'b0;
    pulse_start();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if ({mem_we, mem_a, mem_din, checksum, cpu_rst_n} !== {1'b1, 13'd0, 8'hA5, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_first_write: got we=%b a=%0d d=%h cs=%h crn=%b expected we=1 a=0 d=a5 cs=a5 crn=0",
               mem_we, mem_a, mem_din, checksum, cpu_rst_n);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int idx = 0, writes = 0, cyc = 0;
    bit pacc = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [7:0] pd = '0, sum = '0, d;
    pulse_start();
    while ((idx < DEPTH || pacc) && cyc < 20000) begin
      vectors += 3;
      if (in_ready !== (idx < DEPTH)) begin
        miscompares++;
        $display("FAIL b2b_in_ready idx %0d: got %b expected %b", idx, in_ready, idx < DEPTH);
      end
      if (mem_we !== pacc) begin
        miscompares++;
        $display("FAIL b2b_mem_we idx %0d: got %b expected %b", idx, mem_we, pacc);
      end
      if (checksum !== sum) begin
        miscompares++;
        $display("FAIL b2b_checksum idx %0d: got %h expected %h", idx, checksum, sum);
      end
      if (pacc) begin
        writes++;
        vectors++;
        if ({mem_a, mem_din} !== {pa, pd}) begin
          miscompares++;
          $display("FAIL b2b_write: got a=%0d d=%h expected a=%0d d=%h", mem_a, mem_din, pa, pd);
        end
      end
      d        = 8'(idx);
      in_valid = 1'b1;
      in_data  = d;
      pacc     = (idx < DEPTH);
      pa       = AW'(idx);
      pd       = d;
      if (pacc) begin
        sum += d;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 20000) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d cycles expected < 20000", cyc);
    end
    vectors += 2;
    if ({done, cpu_rst_n, busy, checksum} !== {3'b110, 8'h00}) begin
      miscompares++;
      $display("FAIL b2b_done: got done=%b crn=%b busy=%b cs=%h expected 1 1 0 00", done, cpu_rst_n, busy, checksum);
    end
    if (writes !== DEPTH) begin
      miscompares++;
      $display("FAIL b2b_write_count: got %0d expected %0d", writes, DEPTH);
    end
  endtask

  // Byte index 8192 is still presented on in_valid from the previous task.
  task automatic test_overrun();
    in_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({in_ready, mem_we, mem_a, done} !== {1'b0, 1'b0, 13'd8191, 1'b1}) begin
        miscompares++;
        $display("FAIL overrun cycle %0d: got rdy=%b we=%b a=%0d done=%b expected 0 0 8191 1",
                 i, in_ready, mem_we, mem_a, done);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    int idx = 0, writes = 0, cyc = 0;
    bit pacc = 1'b0, v;
    logic [AW-1:0] pa = '0;
    logic [7:0] sum = '0;
    pulse_start();
    vectors++;
    if ({done, busy, checksum} !== {2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL gaps_restart: got done=%b busy=%b cs=%h expected 0 1 00", done, busy, checksum);
    end
    while ((idx < DEPTH || pacc) && cyc < 40000) begin
      vectors += 3;
      if (in_ready !== (idx < DEPTH)) begin
        miscompares++;
        $display("FAIL gaps_in_ready idx %0d: got %b expected %b", idx, in_ready, idx < DEPTH);
      end
      if (mem_we !== pacc) begin
        miscompares++;
        $display("FAIL gaps_mem_we idx %0d: got %b expected %b", idx, mem_we, pacc);
      end
      if (checksum !== sum) begin
        miscompares++;
        $display("FAIL gaps_checksum idx %0d: got %h expected %h", idx, checksum, sum);
      end
      if (pacc) begin
        writes++;
        vectors++;
        if ({mem_a, mem_din} !== {pa, 8'hFF}) begin
          miscompares++;
          $display("FAIL gaps_write: got a=%0d d=%h expected a=%0d d=ff", mem_a, mem_din, pa);
        end
      end
      v        = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? 8'hFF : 8'h3C;
      pacc     = v && (idx < DEPTH);
      pa       = AW'(idx);
      if (pacc) begin
        sum += 8'hFF;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    vectors += 3;
    if (cyc >= 40000) begin
      miscompares++;
      $display("FAIL gaps_timeout: got %0d cycles expected < 40000", cyc);
    end
    if ({done, cpu_rst_n, checksum} !== {2'b11, 8'h00}) begin
      miscompares++;
      $display("FAIL gaps_done: got done=%b crn=%b cs=%h expected 1 1 00", done, cpu_rst_n, checksum);
    end
    if (writes !== DEPTH) begin
      miscompares++;
      $display("FAIL gaps_write_count: got %0d expected %0d", writes, DEPTH);
    end
  endtask

  task automatic test_reload();
    int idx = 0, writes = 0, cyc = 0;
    bit pacc = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [7:0] sum = '0;
    pulse_start();
    vectors++;
    if ({done, cpu_rst_n, in_ready, busy, checksum} !== {4'b0011, 8'h00}) begin
      miscompares++;
      $display("FAIL reload_entry: got done=%b crn=%b rdy=%b busy=%b cs=%h expected 0 0 1 1 00",
               done, cpu_rst_n, in_ready, busy, checksum);
    end
    while ((idx < DEPTH || pacc) && cyc < 20000) begin
      vectors += 3;
      if ({in_ready, busy} !== {1'(idx < DEPTH), 1'b1}) begin
        miscompares++;
        $display("FAIL reload_status idx %0d: got rdy=%b busy=%b expected %b 1", idx, in_ready, busy, idx < DEPTH);
      end
      if (mem_we !== pacc) begin
        miscompares++;
        $display("FAIL reload_mem_we idx %0d: got %b expected %b", idx, mem_we, pacc);
      end
      if (checksum !== sum) begin
        miscompares++;
        $display("FAIL reload_checksum idx %0d: got %h expected %h", idx, checksum, sum);
      end
      if (pacc) begin
        writes++;
        vectors++;
        if ({mem_a, mem_din} !== {pa, 8'h01}) begin
          miscompares++;
          $display("FAIL reload_write: got a=%0d d=%h expected a=%0d d=01", mem_a, mem_din, pa);
        end
      end
      start    = (idx < DEPTH) && (idx % 1024 == 300);
      in_valid = 1'b1;
      in_data  = 8'h01;
      pacc     = (idx < DEPTH);
      pa       = AW'(idx);
      if (pacc) begin
        sum += 8'h01;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    vectors += 3;
    if (cyc >= 20000) begin
      miscompares++;
      $display("FAIL reload_timeout: got %0d cycles expected < 20000", cyc);
    end
    if ({done, cpu_rst_n, busy, checksum} !== {3'b110, 8'h00}) begin
      miscompares++;
      $display("FAIL reload_done: got done=%b crn=%b busy=%b cs=%h expected 1 1 0 00", done, cpu_rst_n, busy, checksum);
    end
    if (writes !== DEPTH) begin
      miscompares++;
      $display("FAIL reload_write_count: got %0d expected %0d", writes, DEPTH);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_idle();
    test_reset_mid();
    test_back_to_back();
    test_overrun();
    test_gaps();
    test_reload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the 8 KB system ROM image memory.
- Accepts a byte stream from the boot source (SPI flash reader / host link) over a valid/ready handshake.
- Writes the bytes sequentially into the dual-use ROM/shadow RAM starting at address 0.
- Holds the Z80 in reset until the full image is written, then releases it and reports an 8-bit additive checksum.

Parameters:
AW, 13, address width of the target memory
DEPTH, 8192, number of bytes to load; must be <= 2**AW

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begins a load from address 0
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle when in_valid && in_ready
mem_a  out  AW  write address to image memory
mem_din  out  8  write data to image memory
mem_we  out  1  write strobe, one cycle per byte
busy  out  1  high in LOAD and LAST
done  out  1  high in DONE
cpu_rst_n  out  1  CPU reset release; low until image complete
checksum  out  8  running sum of accepted bytes modulo 256

Behaviour:
- Clock and reset: clk is the only clock. rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, addr=0, mem_a=0, mem_din=0, mem_we=0, in_ready=0, busy=0, done=0, cpu_rst_n=0, checksum=0.
- All outputs are registered or decoded from registered state only. No combinational path from in_valid to in_ready.
- States: IDLE, LOAD, LAST, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD next cycle; addr<=0; checksum<=0.
- LOAD:
  - in_ready=1, busy=1.
  - On accept (in_valid && in_ready): next cycle mem_we=1, mem_a=addr, mem_din=in_data; addr<=addr+1; checksum<=checksum+in_data (8-bit wrap).
  - mem_we is 0 in any cycle following a non-accept cycle; in_valid gaps are allowed.
  - Accept with addr==DEPTH-1 -> LAST. in_ready=0 from the next cycle.
- LAST:
  - Exactly one cycle. The final write strobe is issued here.
  - -> DONE.
- DONE:
  - done=1, cpu_rst_n=1, busy=0, in_ready=0, mem_we=0.
  - start=1 -> LOAD, and in that next cycle: done=0, cpu_rst_n=0, addr=0, checksum=0 (reload).
- start while in LOAD or LAST is ignored.
- Latency:
  - Accept to write strobe: 1 cycle.
  - Last accept to done/cpu_rst_n high: 2 cycles.
  - Throughput: 1 byte/cycle.
- Address never wraps. addr stops at DEPTH-1 and in_ready drops, so bytes beyond DEPTH are not accepted.
- mem_a and mem_din hold their last values when mem_we=0.
- Reset mid-load: the next cycle is the reset state. The memory holds a partial image, and cpu_rst_n stays 0 until a later complete load.
- checksum is visible continuously and is final when done=1.

Decomposition:
- Shared package (ace_pkg): state enum loader_state_t {IDLE, LOAD, LAST, DONE}; ROM_AW=13; ROM_DEPTH=8192.
- No sub-module. Single FSM with address counter and checksum accumulator.

Test Plan:
1. Reset, then idle 10 cycles with in_valid=1 -> in_ready=0, mem_we=0, cpu_rst_n=0, done=0 throughout.
2. start, then stream bytes i[7:0] for i=0..8191 back-to-back -> 8192 mem_we pulses with mem_a=i, mem_din=i[7:0]; done and cpu_rst_n high 2 cycles after last accept; checksum=0x00.
3. Stream 0xFF x 8192 with in_valid toggling randomly (about 50%) -> writes only on accepted bytes, addresses contiguous, no duplicates; checksum=0x00; total write count 8192.
4. Present a byte at index 8192 after the last accept -> in_ready=0, no 8193rd write, mem_a remains 8191.
5. rst_n=0 for one cycle after 100 bytes accepted -> next cycle matches the reset state; a fresh start reloads from mem_a=0.
6. From DONE, pulse start and stream 8192 bytes of 0x01 -> done and cpu_rst_n drop the next cycle, reload completes, checksum=0x00 (8192 mod 256); start pulses during LOAD have no effect.
